// File: rtl/reduce_stream_arbiter_if.sv
// Stream bundle between the GLB-side requesters, the reduce_stream_arbiter and the shared reducer.
// The slave modport is the arbiter's view; master is the environment (requesters plus reducer).
interface reduce_stream_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 17
);
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in;
    logic [NUM_REQ-1:0]            req_data_in_valid;
    logic [NUM_REQ-1:0]            req_data_in_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data_out;
    logic [NUM_REQ-1:0]            req_data_out_valid;
    logic [NUM_REQ-1:0]            req_data_out_ready;
    logic [DATA_WIDTH-1:0]         red_data_in;
    logic                          red_data_in_valid;
    logic                          red_data_in_ready;
    logic [DATA_WIDTH-1:0]         red_data_out;
    logic                          red_data_out_valid;
    logic                          red_data_out_ready;

    modport slave (
        input  req_data_in, req_data_in_valid, req_data_out_ready,
               red_data_in_ready, red_data_out, red_data_out_valid,
        output req_data_in_ready, req_data_out, req_data_out_valid,
               red_data_in, red_data_in_valid, red_data_out_ready
    );

    modport master (
        output req_data_in, req_data_in_valid, req_data_out_ready,
               red_data_in_ready, red_data_out, red_data_out_valid,
        input  req_data_in_ready, req_data_out, req_data_out_valid,
               red_data_in, red_data_in_valid, red_data_out_ready
    );
endinterface

// File: rtl/reduce_stream_arbiter.sv
// Round-robin, job-granular arbiter sharing one reducer among NUM_REQ token streams.
// A grant lasts from the first input token until the job's DONE token leaves the reducer.
module reduce_stream_arbiter #(
    parameter int                    NUM_REQ    = 4,
    parameter int                    DATA_WIDTH = 17,
    parameter logic [DATA_WIDTH-1:0] DONE_TOKEN = 17'h10100
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clk_en,
    input  logic                   flush,
    input  logic                   tile_en,
    reduce_stream_arbiter_if.slave bus,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic [15:0]            jobs_done,
    output logic                   proto_err
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FWD   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    logic [IDX_W-1:0]     r_owner;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [15:0]          r_jobs_done;
    logic                 r_proto_err;
    logic [NUM_REQ-1:0]   r_grant;
    logic                 r_busy;

    state_t               w_state_nxt;
    logic [IDX_W-1:0]     w_owner_nxt;
    logic [IDX_W-1:0]     w_rr_nxt;
    logic [15:0]          w_jobs_nxt;
    logic                 w_err_nxt;
    logic [NUM_REQ-1:0]   w_grant_nxt;
    logic                 w_job_end;

    logic                  w_active;
    logic [DATA_WIDTH-1:0] w_own_data;
    logic                  w_own_in_valid;
    logic                  w_own_out_ready;
    logic                  w_in_hs;
    logic                  w_out_hs;
    logic                  w_in_done;
    logic                  w_out_done;

    // First valid requester at or after ptr, wrapping modulo NUM_REQ.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] pick;
        logic [IDX_W:0]   idx;
        pick = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx  = {1'b0, ptr} + (IDX_W+1)'(k);
            idx  = (idx >= (IDX_W+1)'(NUM_REQ)) ? idx - (IDX_W+1)'(NUM_REQ) : idx;
            pick = vld[idx[IDX_W-1:0]] ? idx[IDX_W-1:0] : pick;
        end
        return pick;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    assign w_active        = clk_en & tile_en;
    assign w_own_data      = bus.req_data_in[r_owner*DATA_WIDTH +: DATA_WIDTH];
    assign w_own_in_valid  = bus.req_data_in_valid[r_owner];
    assign w_own_out_ready = bus.req_data_out_ready[r_owner];

    assign w_in_hs    = bus.red_data_in_valid & bus.red_data_in_ready;
    assign w_out_hs   = bus.red_data_out_valid & bus.red_data_out_ready;
    assign w_in_done  = w_in_hs & (bus.red_data_in == DONE_TOKEN);
    assign w_out_done = w_out_hs & (bus.red_data_out == DONE_TOKEN);

    assign grant     = r_grant;
    assign busy      = r_busy;
    assign jobs_done = r_jobs_done;
    assign proto_err = r_proto_err;

    // Zero-latency steering of the owner's streams; every ready/valid is gated by w_active.
    always_comb begin
        bus.red_data_in        = '0;
        bus.red_data_in_valid  = 1'b0;
        bus.req_data_in_ready  = '0;
        bus.req_data_out       = '0;
        bus.req_data_out_valid = '0;
        bus.red_data_out_ready = 1'b0;
        if (r_state == ST_FWD) begin
            bus.red_data_in                = w_own_data;
            bus.red_data_in_valid          = w_active & w_own_in_valid;
            bus.req_data_in_ready[r_owner] = w_active & bus.red_data_in_ready;
        end else begin
            bus.red_data_in_valid = 1'b0;
        end
        if (r_state != ST_IDLE) begin
            bus.req_data_out                = {NUM_REQ{bus.red_data_out}};
            bus.req_data_out_valid[r_owner] = w_active & bus.red_data_out_valid;
            bus.red_data_out_ready          = w_active & w_own_out_ready;
        end else begin
            bus.red_data_out_ready = 1'b0;
        end
    end

    // Next-state and next-register values for the job FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_ptr;
        w_jobs_nxt  = r_jobs_done;
        w_err_nxt   = r_proto_err;
        w_job_end   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_active && (|bus.req_data_in_valid)) begin
                    w_state_nxt = ST_FWD;
                    w_owner_nxt = rr_pick(bus.req_data_in_valid, r_rr_ptr);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FWD: begin
                // Input and output DONE together means the job really finished.
                if (w_out_done && w_in_done) begin
                    w_job_end = 1'b1;
                end else if (w_out_done) begin
                    w_err_nxt = 1'b1;
                end else if (w_in_done) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_FWD;
                end
            end
            ST_DRAIN: begin
                if (w_out_done) begin
                    w_job_end = 1'b1;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_job_end) begin
            w_state_nxt = ST_IDLE;
            w_rr_nxt    = (r_owner == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}} : r_owner + {{(IDX_W-1){1'b0}}, 1'b1};
            w_jobs_nxt  = r_jobs_done + 16'd1;
        end else begin
            w_rr_nxt = r_rr_ptr;
        end
        if (!tile_en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            w_state_nxt = w_state_nxt;
        end
        w_grant_nxt = (w_state_nxt == ST_IDLE) ? {NUM_REQ{1'b0}} : onehot(w_owner_nxt);
    end

    // State and status registers; flush outranks clk_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_jobs_done <= 16'd0;
            r_proto_err <= 1'b0;
            r_grant     <= '0;
            r_busy      <= 1'b0;
        end else if (flush) begin
            r_state     <= ST_IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_jobs_done <= 16'd0;
            r_proto_err <= 1'b0;
            r_grant     <= '0;
            r_busy      <= 1'b0;
        end else if (clk_en) begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_jobs_done <= w_jobs_nxt;
            r_proto_err <= w_err_nxt;
            r_grant     <= w_grant_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end
endmodule

// File: doc/reduce_stream_arbiter.md
# reduce_stream_arbiter

Shares one `reduce_pe_cluster` between `NUM_REQ` sparse value streams. It grants the reducer to one requester for a whole job: from the first token through that job's DONE token leaving the reducer. Input tokens are steered to the reducer, and the reducer's output stream is routed back to the granted requester. The block sits between the GLB-side tile streams and the reducer, and is the only master of the reducer's in/out handshakes.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `DATA_WIDTH`, 17: stream token width. Bit 16 = control flag.
- `DONE_TOKEN`, 17'h10100: end-of-stream token.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `clk_en` in 1: clock enable. 0 = state frozen and all handshakes gated.
- `flush` in 1: synchronous soft reset to the reset state.
- `tile_en` in 1: 0 = block inert. All ready/valid outputs are 0 and state is held in IDLE.
- `req_data_in` in NUM_REQ*DATA_WIDTH: packed requester input tokens. Requester i uses slice [i*17 +: 17].
- `req_data_in_valid` in NUM_REQ: requester token valid.
- `req_data_in_ready` out NUM_REQ: ready back to each requester.
- `req_data_out` out NUM_REQ*DATA_WIDTH: reducer result routed to each requester.
- `req_data_out_valid` out NUM_REQ: result valid per requester.
- `req_data_out_ready` in NUM_REQ: result ready per requester.
- `red_data_in` out DATA_WIDTH: token to reducer.
- `red_data_in_valid` out 1: valid for `red_data_in`.
- `red_data_in_ready` in 1: reducer input ready.
- `red_data_out` in DATA_WIDTH: reducer result.
- `red_data_out_valid` in 1: reducer result valid.
- `red_data_out_ready` out 1: ready to reducer output.
- `grant` out NUM_REQ: one-hot current owner. 0 in IDLE.
- `busy` out 1: 1 in FWD or DRAIN.
- `jobs_done` out 16: count of completed jobs. Wraps at 16'hFFFF→0.
- `proto_err` out 1: sticky protocol error flag.

## Operation
- Registered state: `state` (IDLE/FWD/DRAIN), `owner` index, `rr_ptr`, `jobs_done`, `proto_err`.
- **IDLE:**
  - All ready/valid outputs are 0.
  - If any `req_data_in_valid`, select the first valid requester at or after `rr_ptr`, wrapping modulo NUM_REQ.
  - Next cycle: `owner` = that requester, `grant` = its one-hot, state = FWD.
  - No token is consumed in the arbitration cycle.
- **FWD:**
  - Input path is combinational pass-through for the owner only:
    - `red_data_in` = owner slice.
    - `red_data_in_valid` = owner valid.
    - Owner `req_data_in_ready` = `red_data_in_ready`.
  - Non-owner `req_data_in_ready` = 0.
  - Output path is active (see below).
  - Input handshake carrying `DONE_TOKEN` → DRAIN.
  - Non-DONE control tokens (stop tokens) pass through unchanged and do not change state.
- **DRAIN:**
  - All `req_data_in_ready` = 0 and `red_data_in_valid` = 0.
  - Output path stays active.
- **Output path (FWD and DRAIN):**
  - `red_data_out` is broadcast on every `req_data_out` slice.
  - `req_data_out_valid[owner]` = `red_data_out_valid`; all other valids are 0.
  - `red_data_out_ready` = `req_data_out_ready[owner]`.
- **Job end:** an output handshake of `DONE_TOKEN` while in DRAIN causes:
  - state → IDLE, `grant` → 0;
  - `rr_ptr` = (owner+1) mod NUM_REQ;
  - `jobs_done` += 1.
- **Protocol error:** an output `DONE_TOKEN` handshake in FWD sets `proto_err`. The token is still delivered and the state does not change.
- **Simultaneous input DONE and output DONE in FWD:** treated as a complete job. Go directly to IDLE with the same updates as a job end. `proto_err` is not set.
- **Reset and flush:**
  - `rst_n` low at any time, mid-job included: state = IDLE, `owner` = 0, `rr_ptr` = 0, `jobs_done` = 0, `proto_err` = 0, and all outputs 0 asynchronously.
  - `flush` has the same effect synchronously and has priority over `clk_en`.
  - In-flight reducer contents are not tracked; the reducer is flushed by the same `flush`.
- **`clk_en` = 0:** registers hold. Every ready/valid output is forced to 0, so no handshake completes.
- **`tile_en` = 0:** same gating as `clk_en` = 0. In addition, state is forced to IDLE on the next edge.

## Timing
- Arbitration latency: 1 cycle from the first valid in IDLE to `grant`. The first token can transfer in that grant cycle.
- Data path latency through the arbiter: 0 cycles in both directions. No buffering is added.
- Back-to-back jobs: the cycle after the job-ending output handshake is IDLE. If another requester is valid, the earliest next grant is 1 cycle later, so there is a minimum 1-cycle bubble between jobs.
- `grant`, `busy`, `jobs_done`, `proto_err` are registered outputs. All readies and valids are combinational from state and inputs.
- Fairness: strict round-robin. A continuously valid requester waits at most NUM_REQ-1 jobs.

## Test plan
- **Single job:** requester 0 sends 3,5,DONE; reducer model returns 8,DONE → `grant`=4'b0001 for the whole job, requester 0 receives 8 then DONE, `jobs_done`=1, then IDLE with `grant`=0.
- **Contention:** requesters 1 and 2 both valid from cycle 0, `rr_ptr`=0 → requester 1 is served first, then requester 2, with exactly one IDLE cycle between. Requester 2 sees ready=0 throughout requester 1's job.
- **Backpressure:** `red_data_in_ready` toggles every cycle and `req_data_out_ready[owner]` stays 0 for 5 cycles → no token is lost or duplicated, and the DONE output is held until ready returns.
- **Stop token:** owner sends 1, 17'h10000, 2, DONE → stop token passes untouched and the state stays FWD until DONE.
- **Error and reset:** output DONE injected in FWD → `proto_err`=1 sticky. `rst_n` pulsed low mid-DRAIN → all outputs 0 immediately, `jobs_done`=0, `proto_err`=0.
- **Gating:** `clk_en`=0 for 10 cycles mid-job → no handshakes, state preserved, and the job completes normally after re-enable.
